// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Pipeline hazard controller for the 5-stage RV32I core. It sits beside the
// decode control unit and drives the PC and pipeline-register enables and
// flushes. It does three things:
//   - inserts one bubble for a load-use hazard seen in ID
//   - flushes wrong-path instructions when a branch resolves taken in MEM
//   - freezes the whole pipeline while data memory is busy
// All outputs are combinational from the registered state and the current
// inputs, so they add no latency.
//
// Parameters:
//   FLUSH_CYCLES - cycles after a taken branch during which load-use
//                  detection is masked (1..3)
//   CNT_W        - width of the performance counters
//
// Optional feature (macro HAZARD_PERF_CNT_EN): adds three saturating counters.
//   stall_count - counts load-use bubble cycles
//   flush_count - counts branch flush cycles
//   wait_count  - counts memory-wait freeze cycles
//
// Ports:
//   clk, reset                  - core clock; synchronous active-high reset
//   if_id_opcode/rs1/rs2        - fields of the instruction in IF/ID
//   id_ex_memread, id_ex_rd     - load indication and destination in ID/EX
//   branch_taken                - one-cycle pulse: branch in EX/MEM was taken
//   dmem_wait                   - level signal: data memory is not ready
//   pc_write, if_id_write       - PC and IF/ID enables
//   id_ex_bubble                - forces zero control signals into ID/EX
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                - pipeline-register clears
//   pipe_hold                   - holds ID/EX, EX/MEM and MEM/WB
//   seq_state                   - FSM state: 0 = RUN, 1 = STALL, 2 = FLUSH
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       if_id_opcode,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count,
`endif
  output logic [1:0]       seq_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_r, state_nxt_s;
  logic [1:0] flush_cnt_r, flush_cnt_nxt_s;
  logic       br_pend_r, br_pend_nxt_s;
  logic       hazard_s;
  logic       stall_evt_s, flush_evt_s, wait_evt_s;

  // R-type, store and branch instructions read rs2; all others ignore it.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      7'b0110011: uses_rs2 = 1'b1;
      7'b0100011: uses_rs2 = 1'b1;
      7'b1100011: uses_rs2 = 1'b1;
      default:    uses_rs2 = 1'b0;
    endcase
  endfunction

  // Load-use detection: the load in ID/EX writes a register that the IF/ID
  // instruction reads. x0 is never a real dependency.
  always_comb begin
    hazard_s = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((id_ex_rd == if_id_rs1) ||
                (uses_rs2(if_id_opcode) && (id_ex_rd == if_id_rs2)));
  end

  // Prioritised output decode and next-state computation.
  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    id_ex_bubble    = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    pipe_hold       = 1'b0;
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    br_pend_nxt_s   = br_pend_r;
    stall_evt_s     = 1'b0;
    flush_evt_s     = 1'b0;
    wait_evt_s      = 1'b0;

    if (reset) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      id_ex_bubble    = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem_flush    = 1'b1;
      state_nxt_s     = RUN;
      flush_cnt_nxt_s = 2'd0;
      br_pend_nxt_s   = 1'b0;
    end else if (dmem_wait) begin
      // Freeze everything. A branch seen now is remembered and flushed once
      // memory is ready, so the redirect is not lost.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      wait_evt_s  = 1'b1;
      if (branch_taken) begin
        br_pend_nxt_s = 1'b1;
      end else begin
        br_pend_nxt_s = br_pend_r;
      end
      if (state_r == ILLEGAL) begin
        state_nxt_s = RUN;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (branch_taken || br_pend_r) begin
      // Kill the wrong path in every state. An in-progress flush window is
      // restarted.
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      pc_write      = 1'b1;
      br_pend_nxt_s = 1'b0;
      flush_evt_s   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt_s     = FLUSH;
        flush_cnt_nxt_s = FLUSH_RELOAD;
      end else begin
        state_nxt_s     = RUN;
        flush_cnt_nxt_s = 2'd0;
      end
    end else begin
      case (state_r)
        FLUSH: begin
          // Wrong-path operands are meaningless here, so hazards are masked.
          if (flush_cnt_r <= 2'd1) begin
            state_nxt_s     = RUN;
            flush_cnt_nxt_s = 2'd0;
          end else begin
            state_nxt_s     = FLUSH;
            flush_cnt_nxt_s = flush_cnt_r - 2'd1;
          end
        end
        STALL: begin
          // ID/EX now holds the bubble, so the dependency has been resolved.
          state_nxt_s = RUN;
        end
        RUN: begin
          if (hazard_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_evt_s  = 1'b1;
            state_nxt_s  = STALL;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s     = RUN;
          flush_cnt_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      flush_cnt_r <= 2'd0;
      br_pend_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      br_pend_r   <= br_pend_nxt_s;
    end
  end

  assign seq_state = state_r;

`ifdef HAZARD_PERF_CNT_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
      wait_count  <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt_s) stall_count <= sat_inc(stall_count);
      if (flush_evt_s) flush_count <= sat_inc(flush_count);
      if (wait_evt_s)  wait_count  <= sat_inc(wait_count);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
  localparam int FC = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [6:0]    if_id_opcode = 7'd0;
  logic [4:0]    if_id_rs1 = 5'd0, if_id_rs2 = 5'd0, id_ex_rd = 5'd0;
  logic          id_ex_memread = 1'b0, branch_taken = 1'b0, dmem_wait = 1'b0;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
  logic          ex_mem_flush, pipe_hold;
  logic [1:0]    seq_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_count, flush_count, wait_count;
`endif

  hazard_sequencer #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_id_opcode(if_id_opcode), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .dmem_wait(dmem_wait),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count), .wait_count(wait_count),
`endif
    .seq_state(seq_state)
  );

  // Expected response for one cycle:
  // outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
  typedef struct {
    logic [6:0]    outs;
    logic [1:0]    st;
    bit            chk;
    logic [CW-1:0] sc, fc, wc;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: "how many masked cycles remain", "was last cycle a bubble",
  // "is a branch owed", plus event counts.
  bit m_known = 1'b0;
  bit m_stalled = 1'b0;
  bit m_pend = 1'b0;
  int m_mask = 0;
  int m_sc = 0, m_fc = 0, m_wc = 0;
  localparam int CMAX = (1 << CW) - 1;

  function automatic bit ref_hazard(input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                                    input logic [4:0] r2, input logic [6:0] op);
    bit reads_rs2;
    reads_rs2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    return mr && (rd != 5'd0) && ((rd == r1) || (reads_rs2 && (rd == r2)));
  endfunction

  task automatic cycle(input bit rst, input bit br, input bit wt, input bit mr,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] op);
    exp_t e;
    @(negedge clk);
    reset = rst; branch_taken = br; dmem_wait = wt; id_ex_memread = mr;
    id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2; if_id_opcode = op;
    e.chk = m_known;
    e.st  = (m_mask > 0) ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
    e.sc  = m_sc[CW-1:0]; e.fc = m_fc[CW-1:0]; e.wc = m_wc[CW-1:0];
    if (rst) begin
      e.outs = 7'b0011110;
      m_stalled = 1'b0; m_pend = 1'b0; m_mask = 0;
      m_sc = 0; m_fc = 0; m_wc = 0; m_known = 1'b1;
    end else if (wt) begin
      e.outs = 7'b0000001;
      if (br) m_pend = 1'b1;
      if (m_wc < CMAX) m_wc++;
    end else if (br || m_pend) begin
      e.outs = 7'b1101110;
      m_pend = 1'b0; m_stalled = 1'b0; m_mask = FC - 1;
      if (m_fc < CMAX) m_fc++;
    end else if (m_mask > 0) begin
      e.outs = 7'b1100000;
      m_mask--;
    end else if (m_stalled) begin
      e.outs = 7'b1100000;
      m_stalled = 1'b0;
    end else if (ref_hazard(mr, rd, r1, r2, op)) begin
      e.outs = 7'b0010000;
      m_stalled = 1'b1;
      if (m_sc < CMAX) m_sc++;
    end else begin
      e.outs = 7'b1100000;
    end
    q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it
  // against the oldest queued expectation, mid-way through the low phase.
  initial begin
    exp_t e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, pipe_hold};
        tests++;
        if (got !== e.outs) begin
          fails++;
          $display("FAIL outputs @%0t: got %b required %b", $time, got, e.outs);
        end
        if (e.chk) begin
          tests++;
          if (seq_state !== e.st) begin
            fails++;
            $display("FAIL seq_state @%0t: got %0d required %0d", $time, seq_state, e.st);
          end
`ifdef HAZARD_PERF_CNT_EN
          tests++;
          if ({stall_count, flush_count, wait_count} !== {e.sc, e.fc, e.wc}) begin
            fails++;
            $display("FAIL perf_counts @%0t: got %0d/%0d/%0d required %0d/%0d/%0d", $time,
                     stall_count, flush_count, wait_count, e.sc, e.fc, e.wc);
          end
`endif
        end
      end
    end
  end

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_L = 7'b0000011;

  initial begin
    logic [6:0] ops [5];
    int waited;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_S; ops[3] = OP_B; ops[4] = OP_L;

    // Reset
    cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // Load-use on rs1: bubble, then STALL with hazard still visible, then RUN
    cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, OP_R);
    cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, OP_R);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // Load-use on rs2 (store), then no false stalls
    cycle(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, OP_S);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, OP_R);
    cycle(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, OP_I);
    // Back-to-back loads: second detected again after STALL
    cycle(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, OP_L);
    cycle(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, OP_L);
    cycle(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, OP_L);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // Branch taken during STALL; hazard present during FLUSH is ignored
    cycle(0, 0, 0, 1, 5'd6, 5'd6, 5'd0, OP_R);
    cycle(0, 1, 0, 1, 5'd6, 5'd6, 5'd0, OP_R);
    cycle(0, 0, 0, 1, 5'd6, 5'd6, 5'd0, OP_R);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // dmem_wait for 3 cycles with a branch in the 2nd; flush on the 4th
    cycle(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // Reset mid-FLUSH
    cycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    cycle(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, OP_R);
    cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    // 20 load-use stalls (drives counters into saturation when enabled)
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, OP_R);
      cycle(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, OP_I);
    end
    // Randomised traffic over a small register set to make hazards common
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]);
    end

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #5;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
